alu_rs: RTL and testbench

Reservation station and issue scheduler for the out-of-order core's single-cycle integer ALU. Holds up to DEPTH dispatched ALU/compare operations and captures pending operands from the common data bus (CDB). Issues at most one ready operation per cycle into registered ALU operand/opcode lanes, and registers the ALU result with its destination tag for CDB arbitration. Sits between the dispatcher and the combinational ALU.

---
 rtl/alu_rs.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_rs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs : reservation station and issue scheduler for the single-cycle ALU.
//
// Holds up to DEPTH dispatched ALU/compare operations. Busy operands are
// captured from the common data bus (CDB). At most one ready operation is
// issued per cycle into registered ALU operand/opcode lanes. The ALU result
// is then registered with its destination tag for CDB arbitration.
//
// Optional feature macro: ALU_RS_AGE_EN
//   defined   : age-ordered select (oldest-dispatched ready entry wins)
//   undefined : lowest-index ready entry wins, no age logic compiled
//
// Ports
//   clk_in, rst_in          clock (rising edge), async active-high reset
//   rdy_in                  global enable; low freezes every register
//   flush_in                mispredict flush; empties station and pipeline
//   disp_*                  dispatch request and operation payload
//   rs_full                 all entries valid; dispatch is refused
//   cdb_valid/tag/value     result broadcast used for operand wakeup
//   alu_type..alu_r2        registered inputs to the combinational ALU
//   alu_out                 combinational ALU result
//   res_valid/tag/value     registered result offered to the CDB
// -----------------------------------------------------------------------------
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  input  logic [1:0]       disp_type,
  input  logic [2:0]       disp_details,
  input  logic             disp_diff,
  input  logic [31:0]      disp_v1,
  input  logic [31:0]      disp_v2,
  input  logic             disp_q1_busy,
  input  logic             disp_q2_busy,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic [TAG_W-1:0] disp_dest,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [1:0]       alu_type,
  output logic [2:0]       alu_details,
  output logic             alu_diff,
  output logic [31:0]      alu_r1,
  output logic [31:0]      alu_r2,
  input  logic [31:0]      alu_out,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_value
);

  localparam int IDX_W = $clog2(DEPTH);

  // Entry storage
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_q1_busy;
  logic [DEPTH-1:0] ent_q2_busy;
  logic [DEPTH-1:0] ent_diff;
  logic [1:0]       ent_type    [DEPTH];
  logic [2:0]       ent_details [DEPTH];
  logic [31:0]      ent_v1      [DEPTH];
  logic [31:0]      ent_v2      [DEPTH];
  logic [TAG_W-1:0] ent_q1      [DEPTH];
  logic [TAG_W-1:0] ent_q2      [DEPTH];
  logic [TAG_W-1:0] ent_dest    [DEPTH];

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] pick_vec;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;

  // Dispatch-time operand capture from a same-cycle CDB broadcast
  logic             d_q1_hit;
  logic             d_q2_hit;

  assign rs_full   = &ent_valid;
  assign disp_fire = disp_valid && !rs_full;
  assign ready     = ent_valid & ~ent_q1_busy & ~ent_q2_busy;
  assign d_q1_hit  = cdb_valid && disp_q1_busy && (cdb_tag == disp_q1);
  assign d_q2_hit  = cdb_valid && disp_q2_busy && (cdb_tag == disp_q2);

  // Lowest-index free entry receives the next dispatch.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef ALU_RS_AGE_EN
  // older[j][i] set means entry j was dispatched before entry i. A new entry
  // clears its own row (older than nobody) and sets its column (everyone
  // still valid is older). Stale bits only concern invalid entries and are
  // masked by the ready vector.
  logic [DEPTH-1:0] older [DEPTH];

  always_comb begin
    pick_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pick_vec[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) pick_vec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else if (disp_fire) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != free_idx) begin
            older[free_idx][j] <= 1'b0;
            older[j][free_idx] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign pick_vec = ready;
`endif

  // Priority pick over the candidate vector (already unique when age-ordered)
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Entry payload. Only meaningful while the valid bit is set, so it carries
  // no reset.
  // NOTE: storage arrays are deliberately left unreset; the reset valid bits
  // qualify them, which keeps reset fan-out off the wide datapath.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      // Wakeup of already-resident entries
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && cdb_valid) begin
          if (ent_q1_busy[i] && ent_q1[i] == cdb_tag) begin
            ent_v1[i]      <= cdb_value;
            ent_q1_busy[i] <= 1'b0;
          end
          if (ent_q2_busy[i] && ent_q2[i] == cdb_tag) begin
            ent_v2[i]      <= cdb_value;
            ent_q2_busy[i] <= 1'b0;
          end
        end
      end
      // Dispatch targets a free entry, so it never collides with wakeup above
      if (disp_fire) begin
        ent_type[free_idx]    <= disp_type;
        ent_details[free_idx] <= disp_details;
        ent_diff[free_idx]    <= disp_diff;
        ent_v1[free_idx]      <= d_q1_hit ? cdb_value : disp_v1;
        ent_v2[free_idx]      <= d_q2_hit ? cdb_value : disp_v2;
        ent_q1_busy[free_idx] <= disp_q1_busy && !d_q1_hit;
        ent_q2_busy[free_idx] <= disp_q2_busy && !d_q2_hit;
        ent_q1[free_idx]      <= disp_q1;
        ent_q2[free_idx]      <= disp_q2;
        ent_dest[free_idx]    <= disp_dest;
      end
    end
  end

  // Control state, issue lanes and result register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_valid   <= '0;
      issue_valid <= 1'b0;
      issue_tag   <= '0;
      alu_type    <= '0;
      alu_details <= '0;
      alu_diff    <= 1'b0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_value   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        // alu_* lanes intentionally hold their last values
        ent_valid   <= '0;
        issue_valid <= 1'b0;
        res_valid   <= 1'b0;
      end else begin
        res_valid   <= issue_valid;
        res_tag     <= issue_tag;
        res_value   <= alu_out;
        issue_valid <= sel_found;
        if (sel_found) begin
          alu_type           <= ent_type[sel_idx];
          alu_details        <= ent_details[sel_idx];
          alu_diff           <= ent_diff[sel_idx];
          alu_r1             <= ent_v1[sel_idx];
          alu_r2             <= ent_v2[sel_idx];
          issue_tag          <= ent_dest[sel_idx];
          ent_valid[sel_idx] <= 1'b0;
        end
        // The issued entry is valid and the free entry is not: no overlap
        if (disp_fire) ent_valid[free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs : directed self-checking bench for alu_rs (DEPTH=4, TAG_W=4).
// A small behavioural ALU closes the alu_* -> alu_out loop.
// -----------------------------------------------------------------------------
module tb_alu_rs;

  localparam int TAG_W = 4;
  localparam logic [1:0] T_CMP = 2'd0;
  localparam logic [1:0] T_OP  = 2'd1;
  localparam logic [1:0] T_OPI = 2'd2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             flush_in;
  logic             disp_valid;
  logic [1:0]       disp_type;
  logic [2:0]       disp_details;
  logic             disp_diff;
  logic [31:0]      disp_v1, disp_v2;
  logic             disp_q1_busy, disp_q2_busy;
  logic [TAG_W-1:0] disp_q1, disp_q2, disp_dest;
  logic             rs_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic [1:0]       alu_type;
  logic [2:0]       alu_details;
  logic             alu_diff;
  logic [31:0]      alu_r1, alu_r2;
  logic [31:0]      alu_out;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_value;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] first_r2, second_r2;
  logic [TAG_W-1:0] first_tag, second_tag;

  always #5 clk_in = ~clk_in;

  alu_rs #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_details(disp_details),
    .disp_diff(disp_diff), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_dest(disp_dest),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .alu_type(alu_type), .alu_details(alu_details),
    .alu_diff(alu_diff), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_out(alu_out),
    .res_valid(res_valid), .res_tag(res_tag), .res_value(res_value)
  );

  // Behavioural integer ALU
  function automatic logic [31:0] alu_f(input logic [1:0] t, input logic [2:0] d,
                                        input logic df, input logic [31:0] a,
                                        input logic [31:0] b);
    logic r;
    if (t == T_CMP) begin
      case (d)
        3'd0:    r = (a == b);
        3'd1:    r = (a != b);
        3'd4:    r = ($signed(a) < $signed(b));
        3'd5:    r = ($signed(a) >= $signed(b));
        3'd6:    r = (a < b);
        3'd7:    r = (a >= b);
        default: r = 1'b0;
      endcase
      return {31'd0, r};
    end
    case (d)
      3'd0:    return (t == T_OP && df) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return df ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_type, alu_details, alu_diff, alu_r1, alu_r2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp_op(input logic [1:0] t, input logic [2:0] d, input logic df,
                         input logic [31:0] v1, input logic q1b, input logic [TAG_W-1:0] q1,
                         input logic [31:0] v2, input logic q2b, input logic [TAG_W-1:0] q2,
                         input logic [TAG_W-1:0] dest);
    disp_valid   = 1'b1;
    disp_type    = t;
    disp_details = d;
    disp_diff    = df;
    disp_v1      = v1;
    disp_q1_busy = q1b;
    disp_q1      = q1;
    disp_v2      = v2;
    disp_q2_busy = q2b;
    disp_q2      = q2;
    disp_dest    = dest;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    disp_valid = 1'b0; disp_type = '0; disp_details = '0; disp_diff = 1'b0;
    disp_v1 = '0; disp_v2 = '0; disp_q1_busy = 1'b0; disp_q2_busy = 1'b0;
    disp_q1 = '0; disp_q2 = '0; disp_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;

    // Reset state
    #2;
    check("rst_rs_full", 32'(rs_full), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_alu_r1", alu_r1, 0);
    #6 rst_in = 1'b0;

    // ADDI 5 + 7, dest 6: issue after E1, result after E2
    disp_op(T_OPI, 3'd0, 1'b0, 5, 1'b0, 0, 7, 1'b0, 0, 6);
    tick(); disp_valid = 1'b0;
    check("addi_no_res_e0", 32'(res_valid), 0);
    tick();
    check("addi_alu_r1", alu_r1, 5);
    check("addi_alu_r2", alu_r2, 7);
    check("addi_alu_type", 32'(alu_type), 32'(T_OPI));
    tick();
    check("addi_res_valid", 32'(res_valid), 1);
    check("addi_res_value", res_value, 12);
    check("addi_res_tag", 32'(res_tag), 6);
    tick();
    check("addi_res_drop", 32'(res_valid), 0);

    // SUB waiting on tag 3; broadcast 20 two cycles later; 20 - 8 = 12
    disp_op(T_OP, 3'd0, 1'b1, 0, 1'b1, 3, 8, 1'b0, 0, 7);
    tick(); disp_valid = 1'b0;
    tick(); cdb(3, 20);
    tick(); cdb_valid = 1'b0;
    check("sub_not_issued_on_wakeup", alu_r1, 5);
    tick();
    check("sub_alu_r1", alu_r1, 20);
    check("sub_alu_r2", alu_r2, 8);
    check("sub_alu_diff", 32'(alu_diff), 1);
    tick();
    check("sub_res_valid", 32'(res_valid), 1);
    check("sub_res_value", res_value, 12);
    check("sub_res_tag", 32'(res_tag), 7);

    // Dispatch with q2 busy on tag 5 while tag 5 is broadcast
    disp_op(T_OP, 3'd0, 1'b0, 1, 1'b0, 0, 0, 1'b1, 5, 8);
    cdb(5, 9);
    tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check("dcap_alu_r2", alu_r2, 9);
    check("dcap_alu_r1", alu_r1, 1);
    tick();
    check("dcap_res_value", res_value, 10);
    check("dcap_res_tag", 32'(res_tag), 8);

    // Fill all entries waiting on tag 1
    for (int i = 0; i < 4; i++) begin
      disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 1, 32'((i + 1) * 10), 1'b0, 0, TAG_W'(i + 1));
      tick();
    end
    check("fill_rs_full", 32'(rs_full), 1);
    disp_op(T_OP, 3'd0, 1'b0, 1, 1'b0, 0, 1, 1'b0, 0, 9);
    tick(); disp_valid = 1'b0;
    check("full_drop_rs_full", 32'(rs_full), 1);
    cdb(1, 100);
    tick(); cdb_valid = 1'b0;
    check("full_woken_rs_full", 32'(rs_full), 1);
    tick();
    check("drain0_alu_r2", alu_r2, 10);
    check("drain0_rs_full", 32'(rs_full), 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain_alu_r2", alu_r2, 32'((i + 1) * 10));
      check("drain_res_tag", 32'(res_tag), i);
      check("drain_res_value", res_value, 32'(100 + i * 10));
    end
    tick();
    check("drain_last_res_tag", 32'(res_tag), 4);
    check("drain_last_res_value", res_value, 140);
    tick();
    check("dropped_disp_never_issued", 32'(res_valid), 0);

    // Select policy: entry 1 dispatched before entry 0, both woken together
`ifdef ALU_RS_AGE_EN
    first_r2 = 2; first_tag = 11; second_r2 = 1; second_tag = 10;
`else
    first_r2 = 1; first_tag = 10; second_r2 = 2; second_tag = 11;
`endif
    disp_op(T_OP, 3'd0, 1'b0, 3, 1'b0, 0, 4, 1'b0, 0, 12);
    tick();
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 2, 2, 1'b0, 0, 11);
    tick();
    check("age_filler_alu_r2", alu_r2, 4);
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 2, 1, 1'b0, 0, 10);
    tick(); disp_valid = 1'b0;
    check("age_filler_res_value", res_value, 7);
    check("age_filler_res_tag", 32'(res_tag), 12);
    cdb(2, 50);
    tick(); cdb_valid = 1'b0;
    tick();
    check("age_first_alu_r2", alu_r2, first_r2);
    tick();
    check("age_second_alu_r2", alu_r2, second_r2);
    check("age_first_res_tag", 32'(res_tag), 32'(first_tag));
    check("age_first_res_value", res_value, 50 + first_r2);
    tick();
    check("age_second_res_tag", 32'(res_tag), 32'(second_tag));
    check("age_second_res_value", res_value, 50 + second_r2);

    // Flush with three waiting entries and one op in flight
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 1);
    tick();
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 2);
    tick();
    disp_op(T_OP, 3'd0, 1'b0, 1, 1'b0, 0, 1, 1'b0, 0, 13);
    tick();
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 3);
    tick();
    check("flush_pre_alu_r1", alu_r1, 1);
    // Flush wins over a simultaneous dispatch
    flush_in = 1'b1;
    disp_op(T_OP, 3'd0, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 4);
    tick(); flush_in = 1'b0; disp_valid = 1'b0;
    check("flush_res_valid", 32'(res_valid), 0);
    check("flush_rs_full", 32'(rs_full), 0);
    cdb(3, 77);
    tick(); cdb_valid = 1'b0;
    tick(); tick();
    check("flush_no_issue_res", 32'(res_valid), 0);
    check("flush_alu_r1_held", alu_r1, 1);
    check("flush_alu_r2_held", alu_r2, 1);

    // rdy_in low freezes everything
    rdy_in = 1'b0;
    disp_op(T_OP, 3'd0, 1'b0, 40, 1'b0, 0, 2, 1'b0, 0, 14);
    tick(); tick();
    check("freeze_alu_r1", alu_r1, 1);
    check("freeze_res_valid", 32'(res_valid), 0);
    rdy_in = 1'b1;
    tick(); disp_valid = 1'b0;
    tick();
    check("unfreeze_alu_r1", alu_r1, 40);
    tick();
    check("unfreeze_res_value", res_value, 42);
    check("unfreeze_res_tag", 32'(res_tag), 14);

    // Asynchronous reset in the middle of a cycle
    disp_op(T_OP, 3'd0, 1'b0, 9, 1'b0, 0, 9, 1'b0, 0, 15);
    tick(); disp_valid = 1'b0;
    tick();
    check("pre_rst_alu_r1", alu_r1, 9);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_alu_r1", alu_r1, 0);
    check("async_rst_alu_r2", alu_r2, 0);
    check("async_rst_res_valid", 32'(res_valid), 0);
    check("async_rst_res_value", res_value, 0);
    check("async_rst_res_tag", 32'(res_tag), 0);
    tick();
    rst_in = 1'b0;
    tick();
    check("post_rst_res_valid", 32'(res_valid), 0);
    check("post_rst_rs_full", 32'(rs_full), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
